// File: rtl/mem_port_responder.sv
// mem_port_responder: round-robin arbiter in front of a byte-addressed SRAM.
// One requesting port is granted at a time. A write stores a 16-bit word as
// two bytes (low byte at addr, high byte at addr+1 modulo DEPTH). A read
// returns one byte. Every transaction ends with a one-cycle, one-hot response
// pulse to the granted port. All outputs come straight from flops.
module mem_port_responder #(
   parameter int NPORT  = 4,
   parameter int AW     = 14,
   parameter int DEPTH  = 16384,
   parameter int RD_LAT = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NPORT-1:0]      processor_req,
   input  logic [NPORT-1:0]      mem_read_req,
   input  logic [NPORT-1:0]      mem_write_req,
   input  logic [NPORT*AW-1:0]   addr,
   input  logic [NPORT*16-1:0]   mem_write_data,
   output logic [7:0]            mem_read_data,
   output logic [NPORT-1:0]      processor_resp,
   output logic                  error,
   output logic                  busy
);

   localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);
   localparam logic [PW-1:0] PTR_INIT = PW'(NPORT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WR_LO = 3'd2,
      WR_HI = 3'd3,
      RESP  = 3'd4
   } state_t;

   // One-hot vector with only bit idx set.
   function automatic logic [NPORT-1:0] port_onehot(input logic [PW-1:0] idx);
      logic [NPORT-1:0] v;
      v      = {NPORT{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   // True when the full-width address falls inside the SRAM.
   function automatic logic in_range(input logic [AW-1:0] a);
      return ({1'b0, a} < DEPTH_W);
   endfunction

   // Byte index of the next location, wrapping DEPTH-1 back to 0.
   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
      return (i == LAST_IDX) ? {IW{1'b0}} : (i + IW'(1));
   endfunction

   state_t              state_r;
   state_t              state_nxt_s;
   logic [PW-1:0]       rr_ptr_r;
   logic [PW-1:0]       g_r;
   logic                stale_r;
   logic [IW-1:0]       addr_r;
   logic [15:0]         data_r;
   logic [CW-1:0]       cnt_r;

   logic [AW-1:0]       addr_a_s  [NPORT];
   logic [15:0]         wdata_a_s [NPORT];
   logic [PW-1:0]       cand_s    [NPORT];
   logic [NPORT-1:0]    req_eff_s;
   logic                grant_valid_s;
   logic [PW-1:0]       grant_idx_s;
   logic                sel_rd_s;
   logic                sel_wr_s;
   logic [AW-1:0]       sel_addr_s;
   logic                req_ok_s;
   logic [PW-1:0]       resp_port_s;
   logic [IW-1:0]       lo_idx_s;
   logic [IW-1:0]       hi_idx_s;

   logic [7:0]          mem_r [DEPTH];

   for (genvar i = 0; i < NPORT; i++) begin : g_unpack
      assign addr_a_s[i]  = addr[i*AW +: AW];
      assign wdata_a_s[i] = mem_write_data[i*16 +: 16];
   end

   // The port served last may still hold req in the IDLE cycle right after
   // its response, so it is masked out of that single arbitration.
   always_comb begin
      req_eff_s = processor_req & ~(stale_r ? port_onehot(g_r) : {NPORT{1'b0}});
   end

   // Candidate order for the round-robin search: rr_ptr+1, rr_ptr+2, ...
   always_comb begin
      for (int k = 0; k < NPORT; k++) begin
         cand_s[k] = PW'((int'(rr_ptr_r) + k + 1) % NPORT);
      end
   end

   // First requesting candidate wins the grant.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_idx_s   = {PW{1'b0}};
      for (int k = 0; k < NPORT; k++) begin
         if (!grant_valid_s && req_eff_s[cand_s[k]]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = cand_s[k];
         end else begin
            // an earlier candidate already won, or this one is idle
         end
      end
   end

   assign sel_rd_s    = mem_read_req[grant_idx_s];
   assign sel_wr_s    = mem_write_req[grant_idx_s];
   assign sel_addr_s  = addr_a_s[grant_idx_s];
   assign req_ok_s    = (sel_rd_s ^ sel_wr_s) && in_range(sel_addr_s);
   assign resp_port_s = (state_r == IDLE) ? grant_idx_s : g_r;
   assign lo_idx_s    = addr_r;
   assign hi_idx_s    = wrap_inc(addr_r);

   // Next-state decode; malformed or out-of-range requests go straight to RESP.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_valid_s) begin
               if (req_ok_s) begin
                  if (sel_rd_s) begin
                     state_nxt_s = READ;
                  end else begin
                     state_nxt_s = WR_LO;
                  end
               end else begin
                  state_nxt_s = RESP;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         READ: begin
            if (cnt_r == {CW{1'b0}}) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = READ;
            end
         end
         WR_LO:   state_nxt_s = WR_HI;
         WR_HI:   state_nxt_s = RESP;
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, grant latches and the registered outputs (loaded one cycle ahead
   // from the next state so they line up with the RESP cycle).
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= IDLE;
         rr_ptr_r       <= PTR_INIT;
         g_r            <= {PW{1'b0}};
         stale_r        <= 1'b0;
         addr_r         <= {IW{1'b0}};
         data_r         <= 16'h0000;
         cnt_r          <= {CW{1'b0}};
         processor_resp <= {NPORT{1'b0}};
         mem_read_data  <= 8'h00;
         error          <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         stale_r        <= (state_r == RESP);
         busy           <= (state_nxt_s != IDLE);
         error          <= (state_r == IDLE) && (state_nxt_s == RESP);
         processor_resp <= (state_nxt_s == RESP) ? port_onehot(resp_port_s)
                                                 : {NPORT{1'b0}};
         mem_read_data  <= ((state_r == READ) && (cnt_r == {CW{1'b0}}))
                           ? mem_r[lo_idx_s] : 8'h00;
         if ((state_r == IDLE) && grant_valid_s) begin
            g_r      <= grant_idx_s;
            rr_ptr_r <= grant_idx_s;
            addr_r   <= sel_addr_s[IW-1:0];
            data_r   <= wdata_a_s[grant_idx_s];
            cnt_r    <= CNT_INIT;
         end else if ((state_r == READ) && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - CW'(1);
         end
      end
   end

   // SRAM byte writes; contents are deliberately not cleared by reset, and a
   // reset arriving in WR_HI suppresses the high-byte write.
   always_ff @(posedge clk) begin
      if (reset) begin
         // no SRAM access while in reset
      end else if (state_r == WR_LO) begin
         mem_r[lo_idx_s] <= data_r[7:0];
      end else if (state_r == WR_HI) begin
         mem_r[hi_idx_s] <= data_r[15:8];
      end
   end

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench for mem_port_responder. Expected responses (port, byte,
// error, cycle) are queued when a request is driven and compared when the
// DUT pulses processor_resp. A reduced DEPTH makes addr=DEPTH expressible.
module tb_mem_port_responder;

   localparam int NPORT  = 4;
   localparam int AW     = 14;
   localparam int DEPTH  = 1000;
   localparam int RD_LAT = 2;

   typedef struct {
      int         port;
      logic [7:0] rdata;
      logic       err;
      int         due;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset;
   logic [NPORT-1:0]    processor_req;
   logic [NPORT-1:0]    mem_read_req;
   logic [NPORT-1:0]    mem_write_req;
   logic [NPORT*AW-1:0] addr;
   logic [NPORT*16-1:0] mem_write_data;
   logic [7:0]          mem_read_data;
   logic [NPORT-1:0]    processor_resp;
   logic                error;
   logic                busy;

   exp_t       exp_q[$];
   logic [7:0] model [DEPTH];
   bit [NPORT-1:0] hold;
   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   mem_port_responder #(
      .NPORT(NPORT), .AW(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .processor_req(processor_req),
      .mem_read_req(mem_read_req),
      .mem_write_req(mem_write_req),
      .addr(addr),
      .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data),
      .processor_resp(processor_resp),
      .error(error),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and check any response pulse.
   task automatic tick();
      exp_t e;
      logic [NPORT-1:0] ev;
      @(negedge clk);
      if (processor_resp !== {NPORT{1'b0}}) begin
         chk("resp_onehot", 32'($onehot(processor_resp)), 32'd1);
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'(processor_resp), 32'd0);
         end else begin
            e = exp_q.pop_front();
            ev = {NPORT{1'b0}};
            ev[e.port] = 1'b1;
            chk("resp_port", 32'(processor_resp), 32'(ev));
            chk("rdata", 32'(mem_read_data), 32'(e.rdata));
            chk("error", 32'(error), 32'(e.err));
            chk("resp_cycle", cyc, e.due);
            if (!hold[e.port]) begin
               processor_req[e.port] = 1'b0;
               mem_read_req[e.port]  = 1'b0;
               mem_write_req[e.port] = 1'b0;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Drive a request and queue its expected response. extra = IDLE cycles
   // spent waiting for earlier transactions before this one is granted.
   task automatic issue(input int p, input bit rd, input bit wr,
                        input logic [AW-1:0] a, input logic [15:0] d, input int extra);
      logic       err;
      logic [7:0] rv;
      int         lat;
      processor_req[p]         = 1'b1;
      mem_read_req[p]          = rd;
      mem_write_req[p]         = wr;
      addr[p*AW +: AW]         = a;
      mem_write_data[p*16 +: 16] = d;
      err = (rd == wr) || (int'(a) >= DEPTH);
      rv  = 8'h00;
      if (err) begin
         lat = 1;
      end else if (rd) begin
         lat = RD_LAT + 1;
         rv  = model[int'(a)];
      end else begin
         lat = 3;
         model[int'(a)] = d[7:0];
         model[(int'(a) + 1) % DEPTH] = d[15:8];
      end
      exp_q.push_back('{p, rv, err, cyc + extra + lat});
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      reset          = 1'b1;
      processor_req  = '0;
      mem_read_req   = '0;
      mem_write_req  = '0;
      addr           = '0;
      mem_write_data = '0;
      hold           = '0;
      idle(3);
      chk("rst_resp", 32'(processor_resp), 32'd0);
      chk("rst_rdata", 32'(mem_read_data), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();

      // write then read back both bytes
      issue(0, 1'b0, 1'b1, 14'h0010, 16'hBEEF, 0);
      tick();
      chk("busy_wr", 32'(busy), 32'd1);
      drain(10); idle(2);
      issue(0, 1'b1, 1'b0, 14'h0010, 16'h0000, 0); drain(10); idle(2);
      issue(0, 1'b1, 1'b0, 14'h0011, 16'h0000, 0); drain(10); idle(2);

      // malformed and out-of-range requests
      issue(2, 1'b1, 1'b1, 14'h0010, 16'hFFFF, 0); drain(10); idle(2);
      issue(1, 1'b0, 1'b0, 14'h0010, 16'hFFFF, 0); drain(10); idle(2);
      issue(2, 1'b0, 1'b1, 14'd1000, 16'h5555, 0); drain(10); idle(2);
      issue(2, 1'b1, 1'b0, 14'd1000, 16'h0000, 0); drain(10); idle(2);
      issue(3, 1'b0, 1'b1, 14'h3FFF, 16'h5555, 0); drain(10); idle(2);
      issue(1, 1'b1, 1'b0, 14'h0010, 16'h0000, 0); drain(10); idle(2);

      // high byte wraps to address 0
      issue(3, 1'b0, 1'b1, 14'd999, 16'h1234, 0); drain(10); idle(2);
      issue(3, 1'b1, 1'b0, 14'd999, 16'h0000, 0); drain(10); idle(2);
      issue(0, 1'b1, 1'b0, 14'd0,   16'h0000, 0); drain(10); idle(2);

      // lone port holding req one cycle past its response is not re-served
      hold[2] = 1'b1;
      issue(2, 1'b0, 1'b1, 14'd40, 16'h0F0F, 0);
      drain(10);
      tick();
      processor_req[2] = 1'b0;
      hold[2] = 1'b0;
      tick();
      chk("stale_busy", 32'(busy), 32'd0);
      idle(4);

      // held port 1 vs new requester port 3 in the masked cycle
      hold[1] = 1'b1;
      issue(1, 1'b0, 1'b1, 14'd50, 16'hA0A1, 0);
      drain(10);
      issue(3, 1'b1, 1'b0, 14'h0010, 16'h0000, 1);
      tick();
      processor_req[1] = 1'b0;
      hold[1] = 1'b0;
      drain(10); idle(4);

      // known contents at 21 before the aborted write
      issue(0, 1'b0, 1'b1, 14'd21, 16'hC3C3, 0); drain(10); idle(2);

      // reset lands in WR_HI: low byte written, high byte not
      processor_req[0]      = 1'b1;
      mem_write_req[0]      = 1'b1;
      mem_read_req[0]       = 1'b0;
      addr[0 +: AW]         = 14'd20;
      mem_write_data[15:0]  = 16'hA55A;
      model[20]             = 8'h5A;
      tick();
      tick();
      chk("busy_whi", 32'(busy), 32'd1);
      reset         = 1'b1;
      processor_req = '0;
      mem_write_req = '0;
      tick();
      chk("abort_resp", 32'(processor_resp), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();

      // all ports at once after reset: two full rounds 0,1,2,3
      for (int i = 0; i < NPORT; i++) begin
         issue(i, 1'b0, 1'b1, AW'(100 + 2*i), 16'(16'h1101 * (i + 1)), 4*i);
      end
      drain(40); idle(2);
      for (int i = 0; i < NPORT; i++) begin
         issue(i, 1'b1, 1'b0, AW'(100 + 2*i), 16'h0000, 4*i);
      end
      drain(40); idle(2);

      // contents left by the aborted write
      issue(0, 1'b1, 1'b0, 14'd20, 16'h0000, 0); drain(10); idle(2);
      issue(0, 1'b1, 1'b0, 14'd21, 16'h0000, 0); drain(10); idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
